// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
// Tag width follows ROB_DEPTH; count carries one extra bit so it can represent "full".
package rob_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int CNT_W     = TAG_W + 1;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        bcast;
    logic [4:0]  rd;
    logic [31:0] val;
  } entry_t;
endpackage

// File: rtl/rob_oldest_sel.sv
// Head-relative priority picker: returns the oldest candidate at or after head, plus a found flag.
// Purely combinational; no backpressure.
module rob_oldest_sel
  import rob_pkg::*;
(
  input  logic [TAG_W-1:0]     head,
  input  logic [ROB_DEPTH-1:0] cand,
  output logic [TAG_W-1:0]     idx,
  output logic                 found
);
  logic [TAG_W-1:0] k;

  // Scan youngest-to-oldest so the last hit, i.e. the one closest to head, wins.
  always_comb begin
    idx   = head;
    found = 1'b0;
    k     = '0;
    for (int i = ROB_DEPTH - 1; i >= 0; i--) begin
      k = head + TAG_W'(i);
      if (cand[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rob.sv
// Reorder buffer: tag allocation, writeback by tag, one CDB broadcast and one in-order commit per cycle.
// Broadcast 1 cycle after writeback, commit 1 after broadcast; rdy_in low stalls; ROB_BYPASS_EN forwards writebacks to lookup.
module rob
  import rob_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [31:0]      alu_val,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [31:0]      lsb_val,
  output logic             rd_flag,
  output logic [TAG_W-1:0] rob_reorder,
  output logic [31:0]      rd_val,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  input  logic             flush_in
);
  entry_t               ent [ROB_DEPTH];
  logic [TAG_W-1:0]     head;
  logic [TAG_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [ROB_DEPTH-1:0] cand;
  logic [TAG_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 issue_go;
  logic                 commit_go;

  assign issue_tag = tail;
  assign rob_full  = (count == CNT_W'(ROB_DEPTH));
  assign issue_go  = issue_valid & ~rob_full;
  assign commit_go = ent[head].busy & ent[head].done & ent[head].bcast;

  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      cand[i] = ent[i].busy & ent[i].done & ~ent[i].bcast;
    end
  end

  rob_oldest_sel u_sel (
    .head  (head),
    .cand  (cand),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    q1_ready = ent[q1_tag].busy & ent[q1_tag].done;
    q1_val   = ent[q1_tag].busy ? ent[q1_tag].val : 32'd0;
    q2_ready = ent[q2_tag].busy & ent[q2_tag].done;
    q2_val   = ent[q2_tag].busy ? ent[q2_tag].val : 32'd0;
`ifdef ROB_BYPASS_EN
    if (ent[q1_tag].busy) begin
      if (alu_valid && alu_tag == q1_tag) begin
        q1_ready = 1'b1;
        q1_val   = alu_val;
      end else if (lsb_valid && lsb_tag == q1_tag) begin
        q1_ready = 1'b1;
        q1_val   = lsb_val;
      end
    end
    if (ent[q2_tag].busy) begin
      if (alu_valid && alu_tag == q2_tag) begin
        q2_ready = 1'b1;
        q2_val   = alu_val;
      end else if (lsb_valid && lsb_tag == q2_tag) begin
        q2_ready = 1'b1;
        q2_val   = lsb_val;
      end
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      rd_flag      <= 1'b0;
      commit_valid <= 1'b0;
      if (rst_in) begin
        rob_reorder <= '0;
        rd_val      <= '0;
        commit_tag  <= '0;
        commit_rd   <= '0;
        commit_val  <= '0;
      end
    end else if (!rdy_in) begin
      rd_flag      <= 1'b0;
      commit_valid <= 1'b0;
    end else begin
      // LSB first so a same-tag ALU write lands last and wins.
      if (lsb_valid && ent[lsb_tag].busy) begin
        ent[lsb_tag].done <= 1'b1;
        ent[lsb_tag].val  <= lsb_val;
      end
      if (alu_valid && ent[alu_tag].busy) begin
        ent[alu_tag].done <= 1'b1;
        ent[alu_tag].val  <= alu_val;
      end

      rd_flag <= sel_found;
      if (sel_found) begin
        rob_reorder         <= sel_idx;
        rd_val              <= ent[sel_idx].val;
        ent[sel_idx].bcast  <= 1'b1;
      end

      // Head is never a broadcast candidate when committing, so the clear below cannot collide with bcast.
      commit_valid <= commit_go;
      if (commit_go) begin
        commit_tag <= head;
        commit_rd  <= ent[head].rd;
        commit_val <= ent[head].val;
        ent[head]  <= '0;
        head       <= head + 1'b1;
      end

      if (issue_go) begin
        ent[tail] <= '{busy: 1'b1, done: 1'b0, bcast: 1'b0, rd: issue_rd, val: 32'd0};
        tail      <= tail + 1'b1;
      end

      count <= count + CNT_W'(issue_go) - CNT_W'(commit_go);
    end
  end
endmodule

// File: tb/tb_rob.sv
// Bench for rob: program-order queue model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_rob;
  logic        clk = 1'b0;
  logic        rst, rdy, issue_valid, alu_valid, lsb_valid, flush;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag, q1_tag, q2_tag, alu_tag, lsb_tag, rob_reorder, commit_tag;
  logic        rob_full, q1_ready, q2_ready, rd_flag, commit_valid;
  logic [31:0] q1_val, q2_val, alu_val, lsb_val, rd_val, commit_val;
  logic [4:0]  commit_rd;

  always #5 clk = ~clk;

  rob dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag), .rob_full(rob_full),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val),
    .rd_flag(rd_flag), .rob_reorder(rob_reorder), .rd_val(rd_val),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_val(commit_val), .flush_in(flush)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    bit          done;
    bit          bcast;
    logic [31:0] val;
  } rec_t;

  rec_t        q[$];
  logic [3:0]  ntag;
  logic        m_rd_flag, m_cv;
  logic [3:0]  m_reorder, m_ctag;
  logic [31:0] m_rd_val, m_cval;
  logic [4:0]  m_crd;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic look(input logic [3:0] t, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (q[i]) begin
      if (q[i].tag == t) begin
        r = q[i].done;
        v = q[i].val;
`ifdef ROB_BYPASS_EN
        if (alu_valid && alu_tag == t) begin
          r = 1'b1;
          v = alu_val;
        end else if (lsb_valid && lsb_tag == t) begin
          r = 1'b1;
          v = lsb_val;
        end
`endif
      end
    end
  endtask

  task automatic model_step();
    int          sel;
    int          n0;
    bit          cgo;
    logic [31:0] selval;
    rec_t        r;
    if (rst) begin
      q.delete();
      ntag = 0; m_rd_flag = 0; m_cv = 0; m_reorder = 0; m_rd_val = 0;
      m_ctag = 0; m_crd = 0; m_cval = 0;
      return;
    end
    if (flush) begin
      q.delete();
      ntag = 0; m_rd_flag = 0; m_cv = 0;
      return;
    end
    if (!rdy) begin
      m_rd_flag = 0; m_cv = 0;
      return;
    end
    n0 = q.size();
    sel = -1;
    selval = 0;
    foreach (q[i]) if (sel < 0 && q[i].done && !q[i].bcast) sel = i;
    if (sel >= 0) selval = q[sel].val;
    cgo = (n0 > 0) && q[0].done && q[0].bcast;
    if (cgo) begin
      m_ctag = q[0].tag; m_crd = q[0].rd; m_cval = q[0].val;
    end
    foreach (q[i]) begin
      if (lsb_valid && q[i].tag == lsb_tag) begin q[i].done = 1; q[i].val = lsb_val; end
      if (alu_valid && q[i].tag == alu_tag) begin q[i].done = 1; q[i].val = alu_val; end
    end
    m_rd_flag = (sel >= 0);
    if (sel >= 0) begin
      m_reorder = q[sel].tag; m_rd_val = selval; q[sel].bcast = 1;
    end
    m_cv = cgo;
    if (cgo) void'(q.pop_front());
    if (issue_valid && n0 < 16) begin
      r.tag = ntag; r.rd = issue_rd; r.done = 0; r.bcast = 0; r.val = 0;
      q.push_back(r);
      ntag = ntag + 1;
    end
  endtask

  // One clock: combinational outputs checked before the edge, registered ones just after.
  task automatic cyc();
    logic        r;
    logic [31:0] v;
    #1;
    chk("issue_tag", issue_tag, ntag);
    chk("rob_full", rob_full, q.size() == 16);
    look(q1_tag, r, v);
    chk("q1_ready", q1_ready, r);
    chk("q1_val", q1_val, v);
    look(q2_tag, r, v);
    chk("q2_ready", q2_ready, r);
    chk("q2_val", q2_val, v);
    @(posedge clk);
    model_step();
    #1;
    chk("rd_flag", rd_flag, m_rd_flag);
    chk("rob_reorder", rob_reorder, m_reorder);
    chk("rd_val", rd_val, m_rd_val);
    chk("commit_valid", commit_valid, m_cv);
    chk("commit_tag", commit_tag, m_ctag);
    chk("commit_rd", commit_rd, m_crd);
    chk("commit_val", commit_val, m_cval);
  endtask

  task automatic idle();
    issue_valid = 0; alu_valid = 0; lsb_valid = 0; flush = 0; rdy = 1; rst = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  task automatic alu_wr(input logic [3:0] t, input logic [31:0] v);
    idle(); alu_valid = 1; alu_tag = t; alu_val = v; cyc(); alu_valid = 0;
  endtask

  task automatic issue1(input logic [4:0] rd);
    idle(); issue_valid = 1; issue_rd = rd; cyc(); issue_valid = 0;
  endtask

  initial begin
    idle();
    rst = 1; issue_rd = 0; q1_tag = 0; q2_tag = 0;
    alu_tag = 0; alu_val = 0; lsb_tag = 0; lsb_val = 0;
    repeat (2) @(posedge clk);
    model_step();
    #1;
    do_reset();
    chk("rst rd_flag", rd_flag, 0);
    chk("rst commit_valid", commit_valid, 0);
    chk("rst rd_val", rd_val, 0);
    chk("rst issue_tag", issue_tag, 0);
    chk("rst rob_full", rob_full, 0);

    // Three issues, then out-of-order ALU completion.
    for (int i = 0; i < 3; i++) begin
      chk("alloc tag", issue_tag, i);
      issue1(5'(5 + i));
    end
    chk("alloc tag 3", issue_tag, 3);
    chk("not full", rob_full, 0);
    alu_wr(4'd1, 32'hAA);
    alu_wr(4'd0, 32'h55);
    chk("bcast1 flag", rd_flag, 1);
    chk("bcast1 tag", rob_reorder, 1);
    chk("bcast1 val", rd_val, 32'hAA);
    idle(); cyc();
    chk("bcast2 tag", rob_reorder, 0);
    chk("bcast2 val", rd_val, 32'h55);
    cyc();
    chk("commit1 valid", commit_valid, 1);
    chk("commit1 tag", commit_tag, 0);
    chk("commit1 rd", commit_rd, 5);
    chk("commit1 val", commit_val, 32'h55);
    cyc();
    chk("commit2 tag", commit_tag, 1);
    chk("commit2 rd", commit_rd, 6);
    chk("commit2 val", commit_val, 32'hAA);

    // Fill, overflow attempt, then free one slot and wrap.
    do_reset();
    for (int i = 0; i < 16; i++) issue1(5'(i + 1));
    chk("full", rob_full, 1);
    chk("full tag", issue_tag, 0);
    issue1(5'd31);
    chk("full after 17th", rob_full, 1);
    alu_wr(4'd0, 32'h1234);
    idle(); cyc(); cyc();
    chk("commit frees", commit_valid, 1);
    chk("not full after commit", rob_full, 0);
    chk("wrap tag", issue_tag, 0);

    // Simultaneous ALU/LSB writebacks to different tags.
    idle(); alu_valid = 1; alu_tag = 2; alu_val = 1; lsb_valid = 1; lsb_tag = 3; lsb_val = 2;
    q1_tag = 2;
`ifdef ROB_BYPASS_EN
    #1; chk("bypass ready", q1_ready, 1); chk("bypass val", q1_val, 1);
`else
    #1; chk("no bypass ready", q1_ready, 0);
`endif
    cyc(); idle(); cyc();
    chk("dual bcast a", rob_reorder, 2);
    chk("dual bcast a val", rd_val, 1);
    cyc();
    chk("dual bcast b", rob_reorder, 3);
    chk("dual bcast b val", rd_val, 2);

    // Flush while broadcasting; stale writeback afterwards must be ignored.
    do_reset();
    for (int i = 0; i < 5; i++) issue1(5'(i + 10));
    alu_wr(4'd1, 32'h99);
    idle(); flush = 1; cyc(); flush = 0;
    chk("flush rd_flag", rd_flag, 0);
    chk("flush commit_valid", commit_valid, 0);
    chk("flush issue_tag", issue_tag, 0);
    alu_wr(4'd2, 32'h77);
    q1_tag = 2; idle(); cyc();
    chk("stale wb ready", q1_ready, 0);
    chk("stale wb bcast", rd_flag, 0);

    // Stall with a committable head.
    do_reset();
    issue1(5'd3);
    alu_wr(4'd0, 32'hBEEF);
    idle(); cyc();
    for (int i = 0; i < 3; i++) begin
      rdy = 0; cyc();
      chk("stall no commit", commit_valid, 0);
    end
    rdy = 1; cyc();
    chk("post-stall commit", commit_valid, 1);
    chk("post-stall val", commit_val, 32'hBEEF);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 599) == 0);
      rdy         = ($urandom_range(0, 9) != 0);
      flush       = rdy && ($urandom_range(0, 149) == 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_rd    = 5'($urandom);
      alu_valid   = ($urandom_range(0, 9) < 5);
      alu_tag     = 4'($urandom);
      alu_val     = $urandom;
      lsb_valid   = ($urandom_range(0, 9) < 4);
      lsb_tag     = ($urandom_range(0, 3) == 0) ? alu_tag : 4'($urandom);
      lsb_val     = $urandom;
      q1_tag      = 4'($urandom);
      q2_tag      = 4'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rob.md
# rob

Reorder buffer for the out-of-order RISC-V core. It allocates the 4-bit rename tag that the reservation station and LSB carry with each instruction, and collects results from the ALU and LSB by tag. It drives the CDB broadcast (`rd_flag`/`rob_reorder`/`rd_val`) that wakes waiting RS operands, and retires instructions in program order to the register file.

## Interface
- `ROB_DEPTH`, 16: number of entries; power of two; tag width is `$clog2(ROB_DEPTH)` (4 at default).
- `clk_in` input 1: clock.
- `rst_in` input 1: reset. Synchronous, active-high.
- `rdy_in` input 1: global enable. Low means stall.
- `issue_valid` input 1: decode allocates an entry this cycle.
- `issue_rd` input 5: destination register. x0 means no writeback.
- `issue_tag` output 4: tag the next allocation receives (= tail).
- `rob_full` output 1: no free entry.
- `q1_tag`, `q2_tag` input 4 each: operand lookup tags from rename.
- `q1_ready`, `q2_ready` output 1 each: the looked-up entry holds a result.
- `q1_val`, `q2_val` output 32 each: that result.
- `alu_valid` input 1, `alu_tag` input 4, `alu_val` input 32: ALU writeback.
- `lsb_valid` input 1, `lsb_tag` input 4, `lsb_val` input 32: load writeback.
- `rd_flag` output 1, `rob_reorder` output 4, `rd_val` output 32: CDB broadcast.
- `commit_valid` output 1, `commit_tag` output 4, `commit_rd` output 5, `commit_val` output 32: in-order retire.
- `flush_in` input 1: mispredict flush.

## Operation
- Per-entry state: `busy`, `done`, `bcast`, `rd`[4:0], `val`[31:0]. Circular buffer with `head`/`tail` pointers (4-bit, natural wrap) and a 5-bit `count`.
- **Issue.** When `issue_valid` and `!rob_full`: entry[tail] gets busy=1, done=0, bcast=0, rd=issue_rd, and tail advances. `issue_valid` while full is ignored, with no state change. `rob_full` is `count==ROB_DEPTH` and does not account for a same-cycle commit.
- **Writeback.** On `alu_valid`, entry[alu_tag] gets done=1 and val=alu_val. LSB works the same way. Both may write in the same cycle to different tags. If both target the same tag, ALU wins. Writeback to a non-busy entry is ignored.
- **Broadcast.** Each cycle, the oldest entry (searching from head) with busy&done&!bcast is selected. Registered outputs: `rd_flag`=1, `rob_reorder`=tag, `rd_val`=val; the entry's bcast is set. At most one broadcast per cycle. Otherwise `rd_flag`=0 and tag/val hold.
- **Commit.** When entry[head] is busy&done&bcast: registered `commit_valid`=1 with tag/rd/val, the entry is cleared, and head advances. At most one commit per cycle. Issue and commit in the same cycle leave `count` unchanged.
- **Lookup.** Combinational. `qN_ready`=busy&done of entry[qN_tag], `qN_val`=its val. Non-busy tag gives ready=0, val=0.
- **Flush.** `flush_in` takes priority over issue, writeback, broadcast and commit. All busy bits clear, head=tail=count=0, and `rd_flag`/`commit_valid` are 0 the next cycle.
- **Stall.** `rdy_in`=0: no state change. `rd_flag` and `commit_valid` register 0.

## Timing
- Reset values: `rd_flag`=0, `commit_valid`=0, `rob_reorder`=0, `rd_val`=0, `commit_tag`=0, `commit_rd`=0, `commit_val`=0. All entries are non-busy, so `rob_full`=0 and `issue_tag`=0.
- Reset takes priority over flush and stall. A reset mid-operation discards everything.
- Latencies:
  - Writeback at edge N: earliest broadcast visible after edge N+1, earliest commit visible after edge N+2.
  - Issue at edge N: the entry is lookup-visible immediately after edge N.
- `issue_tag` and `rob_full` are combinational from registers only.

## Configuration
- `ROB_BYPASS_EN` defined: lookup also forwards same-cycle writebacks. If `alu_valid` and `alu_tag==qN_tag`, then ready=1 and val=alu_val. LSB is checked next. Stored results are used otherwise.
- Not defined: lookup reflects stored state only, one cycle after writeback.

## Structure
- Shared package: `ROB_DEPTH`, tag width, the entry struct (busy/done/bcast/rd/val), and the x0 constant.
- One sub-module, `rob_oldest_sel`: a head-relative priority picker returning the oldest done-not-broadcast index plus a found flag.

## Test plan
- Reset, then issue 3 instructions (rd=5,6,7): `issue_tag` reads 0,1,2, then 3; `rob_full`=0.
- ALU writes tag1=0xAA, then tag0=0x55:
  - Broadcast order is tag1 then tag0 (oldest ready first), on consecutive cycles.
  - Commits follow: tag0 (rd=5, 0x55), then tag1 (rd=6, 0xAA).
- Fill all 16 entries: `rob_full`=1, and a 17th `issue_valid` is ignored. Commit one: `rob_full`=0, and the next `issue_tag` is 0 (wrap).
- Same-cycle ALU tag2=1 and LSB tag3=2: both stored, broadcasts on two consecutive cycles. With `ROB_BYPASS_EN`, `q1_tag`=2 in that cycle gives ready=1, val=1.
- Flush with 5 entries busy and one broadcasting: next cycle `rd_flag`=0, `commit_valid`=0, `issue_tag`=0, and a stale writeback to tag 2 is ignored.
- `rdy_in`=0 for 3 cycles with a done head: no commit; the commit appears in the first cycle after `rdy_in` returns.
